game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/pong_pkg.sv | 26 ++
 rtl/game_state_ctrl_if.sv | 40 ++++
 rtl/game_state_ctrl_btn_edge.sv | 36 +++
 rtl/game_state_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Purpose  : Shared types and constants for the game state controller:
//             game state encoding, score width and parameter defaults.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int c_score_w         = 4;
    localparam int c_tick_cnt_w      = 8;
    localparam int c_win_score_def   = 5;
    localparam int c_serve_ticks_def = 60;

    typedef enum logic [2:0] {
        MENU     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4,
        PAUSE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/game_state_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_ctrl_if
//  Purpose  : Bundles the controller's strobes, buttons and game outputs.
//  Signals  : tick, p1_up, p1_down, p1_fire, p1_goal, p2_goal  (to controller)
//             state, mode_sel, p1_score, p2_score, ball_en,
//             serve_dir, winner                                 (from controller)
//  Modports : master - drives inputs / observes outputs
//             slave  - the controller side
//  Revision : 1.0 - initial release
// ============================================================================
interface game_state_ctrl_if;
    import pong_pkg::*;

    logic                 tick;
    logic                 p1_up;
    logic                 p1_down;
    logic                 p1_fire;
    logic                 p1_goal;
    logic                 p2_goal;
    logic [2:0]           state;
    logic                 mode_sel;
    logic [c_score_w-1:0] p1_score;
    logic [c_score_w-1:0] p2_score;
    logic                 ball_en;
    logic                 serve_dir;
    logic                 winner;

    modport master (
        output tick, p1_up, p1_down, p1_fire, p1_goal, p2_goal,
        input  state, mode_sel, p1_score, p2_score, ball_en, serve_dir, winner
    );

    modport slave (
        input  tick, p1_up, p1_down, p1_fire, p1_goal, p2_goal,
        output state, mode_sel, p1_score, p2_score, ball_en, serve_dir, winner
    );

endinterface
`default_nettype wire

// File: rtl/game_state_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module   : btn_edge
//  Purpose  : Two-flop synchronizer for an asynchronous button followed by a
//             rising-edge detector producing a one-cycle pulse.
//  Ports    : clk, rst_n (async, active-low), btn_raw (async in),
//             pulse (one clk cycle per press)
//  Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic btn_raw,
    output logic      pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign pulse = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_ctrl
//  Purpose  : Pong game flow controller: menu, serve countdown, play, point
//             scoring, game over and (optionally) pause.
//  Ports    : clk, rst_n (async, active-low)
//             bus (game_state_ctrl_if.slave): tick, p1_up, p1_down, p1_fire,
//             p1_goal, p2_goal in; state, mode_sel, p1_score, p2_score,
//             ball_en, serve_dir, winner out
//  Config   : GAME_PAUSE_EN - when defined, fire in PLAY pauses the game.
//  Revision : 1.0 - initial release
// ============================================================================
module game_state_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = c_win_score_def,
    parameter int SERVE_TICKS = c_serve_ticks_def
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    game_state_ctrl_if.slave   bus
);

    localparam logic [c_score_w-1:0]    c_win        = c_score_w'(WIN_SCORE);
    localparam logic [c_tick_cnt_w-1:0] c_serve_last = c_tick_cnt_w'(SERVE_TICKS);

    logic w_up, w_down, w_fire;

    btn_edge u_btn_up   (.clk(clk), .rst_n(rst_n), .btn_raw(bus.p1_up),   .pulse(w_up));
    btn_edge u_btn_down (.clk(clk), .rst_n(rst_n), .btn_raw(bus.p1_down), .pulse(w_down));
    btn_edge u_btn_fire (.clk(clk), .rst_n(rst_n), .btn_raw(bus.p1_fire), .pulse(w_fire));

    state_t                  r_state,     w_state_nxt;
    logic                    r_mode_sel,  w_mode_sel_nxt;
    logic [c_score_w-1:0]    r_p1_score,  w_p1_score_nxt;
    logic [c_score_w-1:0]    r_p2_score,  w_p2_score_nxt;
    logic                    r_ball_en,   w_ball_en_nxt;
    logic                    r_serve_dir, w_serve_dir_nxt;
    logic                    r_winner,    w_winner_nxt;
    logic                    r_scorer,    w_scorer_nxt;  // 0 = P1 scored
    logic [c_tick_cnt_w-1:0] r_tick_cnt,  w_tick_cnt_nxt;

    logic [c_score_w-1:0]    w_p1_sat, w_p2_sat;
    logic [c_tick_cnt_w-1:0] w_cnt_inc;

    // Saturating increments keep scores from ever passing the winning value.
    assign w_p1_sat  = (r_p1_score == c_win) ? r_p1_score : r_p1_score + 1'b1;
    assign w_p2_sat  = (r_p2_score == c_win) ? r_p2_score : r_p2_score + 1'b1;
    assign w_cnt_inc = r_tick_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MENU;
            r_mode_sel  <= 1'b0;
            r_p1_score  <= '0;
            r_p2_score  <= '0;
            r_ball_en   <= 1'b0;
            r_serve_dir <= 1'b1;
            r_winner    <= 1'b0;
            r_scorer    <= 1'b0;
            r_tick_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode_sel  <= w_mode_sel_nxt;
            r_p1_score  <= w_p1_score_nxt;
            r_p2_score  <= w_p2_score_nxt;
            r_ball_en   <= w_ball_en_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_winner    <= w_winner_nxt;
            r_scorer    <= w_scorer_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mode_sel_nxt  = r_mode_sel;
        w_p1_score_nxt  = r_p1_score;
        w_p2_score_nxt  = r_p2_score;
        w_serve_dir_nxt = r_serve_dir;
        w_winner_nxt    = r_winner;
        w_scorer_nxt    = r_scorer;
        // Counter rests at zero outside SERVE so every entry starts fresh.
        w_tick_cnt_nxt  = '0;

        case (r_state)
            MENU: begin
                if (w_up && !w_down) begin
                    w_mode_sel_nxt = 1'b1;
                end else if (w_down && !w_up) begin
                    w_mode_sel_nxt = 1'b0;
                end
                if (w_fire) begin
                    w_p1_score_nxt  = '0;
                    w_p2_score_nxt  = '0;
                    w_serve_dir_nxt = 1'b1;
                    w_state_nxt     = SERVE;
                end
            end
            SERVE: begin
                w_tick_cnt_nxt = r_tick_cnt;
                if (bus.tick) begin
                    if (w_cnt_inc == c_serve_last) begin
                        w_state_nxt = PLAY;
                    end else begin
                        w_tick_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            PLAY: begin
                // Goals take priority over everything else in PLAY; a tie
                // scores nothing and re-serves in the same direction.
                if (bus.p1_goal && bus.p2_goal) begin
                    w_state_nxt = SERVE;
                end else if (bus.p1_goal) begin
                    w_scorer_nxt = 1'b0;
                    w_state_nxt  = POINT;
                end else if (bus.p2_goal) begin
                    w_scorer_nxt = 1'b1;
                    w_state_nxt  = POINT;
                end
`ifdef GAME_PAUSE_EN
                else if (w_fire) begin
                    w_state_nxt = PAUSE;
                end
`endif
            end
            POINT: begin
                // Serve goes toward the player who conceded.
                if (!r_scorer) begin
                    w_p1_score_nxt = w_p1_sat;
                    if (w_p1_sat == c_win) begin
                        w_winner_nxt = 1'b0;
                        w_state_nxt  = GAMEOVER;
                    end else begin
                        w_serve_dir_nxt = 1'b1;
                        w_state_nxt     = SERVE;
                    end
                end else begin
                    w_p2_score_nxt = w_p2_sat;
                    if (w_p2_sat == c_win) begin
                        w_winner_nxt = 1'b1;
                        w_state_nxt  = GAMEOVER;
                    end else begin
                        w_serve_dir_nxt = 1'b0;
                        w_state_nxt     = SERVE;
                    end
                end
            end
            GAMEOVER: begin
                if (w_fire) begin
                    w_state_nxt = MENU;
                end
            end
            PAUSE: begin
`ifdef GAME_PAUSE_EN
                if (w_fire) begin
                    w_state_nxt = PLAY;
                end
`else
                w_state_nxt = MENU;
`endif
            end
            default: begin
                w_state_nxt = MENU;
            end
        endcase

        // Registered from the next state so ball_en tracks PLAY exactly.
        w_ball_en_nxt = (w_state_nxt == PLAY);
    end

    assign bus.state     = r_state;
    assign bus.mode_sel  = r_mode_sel;
    assign bus.p1_score  = r_p1_score;
    assign bus.p2_score  = r_p2_score;
    assign bus.ball_en   = r_ball_en;
    assign bus.serve_dir = r_serve_dir;
    assign bus.winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_state_ctrl
//  Purpose  : Directed self-checking bench for game_state_ctrl
//             (WIN_SCORE=2, SERVE_TICKS=3). Honors GAME_PAUSE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_state_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    game_state_ctrl_if bus ();

    game_state_ctrl #(
        .WIN_SCORE  (2),
        .SERVE_TICKS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 up, 1 down, 2 fire, 3 up+down together
    task automatic press(input int which, input int hold);
        case (which)
            0: bus.p1_up   = 1'b1;
            1: bus.p1_down = 1'b1;
            2: bus.p1_fire = 1'b1;
            default: begin bus.p1_up = 1'b1; bus.p1_down = 1'b1; end
        endcase
        cyc(hold);
        bus.p1_up   = 1'b0;
        bus.p1_down = 1'b0;
        bus.p1_fire = 1'b0;
        cyc(4);
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        cyc(1);
    endtask

    // One-cycle goal strobe; returns 1ns after the edge that sampled it.
    task automatic goal(input logic g1, input logic g2, input logic tk);
        bus.p1_goal = g1;
        bus.p2_goal = g2;
        bus.tick    = tk;
        cyc(1);
        bus.p1_goal = 1'b0;
        bus.p2_goal = 1'b0;
        bus.tick    = 1'b0;
    endtask

    task automatic serve_to_play();
        tick_once();
        tick_once();
        tick_once();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        bus.tick = 1'b0; bus.p1_up = 1'b0; bus.p1_down = 1'b0;
        bus.p1_fire = 1'b0; bus.p1_goal = 1'b0; bus.p2_goal = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", bus.state, 0);
        check("rst_mode", bus.mode_sel, 0);
        check("rst_p1", bus.p1_score, 0);
        check("rst_p2", bus.p2_score, 0);
        check("rst_ball", bus.ball_en, 0);
        check("rst_dir", bus.serve_dir, 1);
        check("rst_win", bus.winner, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Menu selection
        press(0, 4);   check("mode_up1", bus.mode_sel, 1);
        press(1, 4);   check("mode_dn1", bus.mode_sel, 0);
        press(0, 4);   check("mode_up2", bus.mode_sel, 1);
        press(1, 4);   check("mode_dn2", bus.mode_sel, 0);
        press(0, 100); check("mode_hold", bus.mode_sel, 1);
        press(3, 4);   check("mode_both", bus.mode_sel, 1);
        goal(1'b1, 1'b0, 1'b0); cyc(1);
        check("menu_goal_ign", bus.p1_score, 0);
        check("menu_state", bus.state, 0);

        // Serve countdown
        press(2, 4);
        check("serve_enter", bus.state, 1);
        check("serve_dir0", bus.serve_dir, 1);
        tick_once(); tick_once();
        check("serve_2ticks", bus.state, 1);
        check("serve_ball0", bus.ball_en, 0);
        tick_once();
        check("play_enter", bus.state, 2);
        check("play_ball", bus.ball_en, 1);
        press(1, 4);
        check("play_dn_ign", bus.mode_sel, 1);

`ifdef GAME_PAUSE_EN
        press(2, 4);
        check("pause_enter", bus.state, 5);
        check("pause_ball", bus.ball_en, 0);
        goal(1'b0, 1'b1, 1'b0); cyc(1);
        check("pause_goal_ign", bus.p2_score, 0);
        check("pause_hold", bus.state, 5);
        press(2, 4);
        check("pause_exit", bus.state, 2);
        check("pause_exit_ball", bus.ball_en, 1);
`else
        press(2, 4);
        check("play_fire_ign", bus.state, 2);
        check("play_fire_ball", bus.ball_en, 1);
`endif

        // P2 scores with a coincident tick: the goal wins
        goal(1'b0, 1'b1, 1'b1);
        check("point_state", bus.state, 3);
        check("point_ball", bus.ball_en, 0);
        cyc(1);
        check("p2_pt_state", bus.state, 1);
        check("p2_pt_score", bus.p2_score, 1);
        check("p2_pt_dir", bus.serve_dir, 0);

        // P1 scores
        serve_to_play();
        goal(1'b1, 1'b0, 1'b0); cyc(1);
        check("p1_pt_score", bus.p1_score, 1);
        check("p1_pt_dir", bus.serve_dir, 1);
        check("p1_pt_state", bus.state, 1);
        goal(1'b1, 1'b0, 1'b0); cyc(1);
        check("serve_goal_ign", bus.p1_score, 1);
        check("serve_goal_st", bus.state, 1);

        // Tie goals
        serve_to_play();
        goal(1'b1, 1'b1, 1'b0);
        check("tie_state", bus.state, 1);
        check("tie_p1", bus.p1_score, 1);
        check("tie_p2", bus.p2_score, 1);
        check("tie_dir", bus.serve_dir, 1);

        // P1 wins
        serve_to_play();
        goal(1'b1, 1'b0, 1'b0); cyc(1);
        check("go_state", bus.state, 4);
        check("go_p1", bus.p1_score, 2);
        check("go_winner", bus.winner, 0);
        check("go_ball", bus.ball_en, 0);
        goal(1'b0, 1'b1, 1'b0); cyc(1);
        check("go_goal_ign", bus.p2_score, 1);
        press(2, 4);
        check("go_to_menu", bus.state, 0);
        check("go_mode_kept", bus.mode_sel, 1);
        check("menu_p1_hold", bus.p1_score, 2);

        // New game, reach 1:1 in PLAY, then async reset
        press(2, 4);
        check("new_p1_clr", bus.p1_score, 0);
        serve_to_play();
        goal(1'b0, 1'b1, 1'b0); cyc(1);
        serve_to_play();
        goal(1'b1, 1'b0, 1'b0); cyc(1);
        serve_to_play();
        check("pre_rst_state", bus.state, 2);
        check("pre_rst_p2", bus.p2_score, 1);
        rst_n = 1'b0;
        #2;
        check("arst_state", bus.state, 0);
        check("arst_p1", bus.p1_score, 0);
        check("arst_p2", bus.p2_score, 0);
        check("arst_ball", bus.ball_en, 0);
        check("arst_mode", bus.mode_sel, 0);
        check("arst_dir", bus.serve_dir, 1);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("post_rst_state", bus.state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
